// File: rtl/microwave_pkg.sv
// Shared constants for the microwave cook timer: state encodings, BCD digit width and limits.
package microwave_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SET   = 3'd1;
  localparam logic [2:0] ST_COOK  = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_down_counter.sv
// Three-digit M:SS BCD register with clear/load/shift/decrement controls and a zero flag.
module bcd_down_counter
  import microwave_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_ld_mins,
  input  logic [BCD_W-1:0] i_ld_tens,
  input  logic [BCD_W-1:0] i_ld_ones,
  input  logic             i_shift,
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_dec,
  output logic [BCD_W-1:0] o_mins,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_ones,
  output logic             o_zero
);

  logic [BCD_W-1:0] r_mins;
  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_mins <= '0;
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_load) begin
      r_mins <= i_ld_mins;
      r_tens <= i_ld_tens;
      r_ones <= i_ld_ones;
    end else if (i_shift) begin
      r_mins <= r_tens;
      r_tens <= r_ones;
      r_ones <= i_digit;
    end else if (i_dec && !o_zero) begin
      // Borrow ripples ones -> tens -> minutes; 0:00 is held by the zero guard.
      if (r_ones != '0) begin
        r_ones <= r_ones - 4'd1;
      end else begin
        r_ones <= SEC_ONES_MAX;
        if (r_tens != '0) begin
          r_tens <= r_tens - 4'd1;
        end else begin
          r_tens <= SEC_TENS_MAX;
          r_mins <= r_mins - 4'd1;
        end
      end
    end
  end

  assign o_mins = r_mins;
  assign o_tens = r_tens;
  assign o_ones = r_ones;
  assign o_zero = (r_mins == '0) && (r_tens == '0) && (r_ones == '0);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer FSM: keypad entry, start/stop/clear, door interlock and 1 Hz countdown.
// Optional quick start (load/add 30 s on start) is enabled by defining MICROWAVE_QUICK_START_EN.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned MAX_MINS        = 9,
  parameter int unsigned QUICK_SECS_TENS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             key_valid,
  input  logic [BCD_W-1:0] key_digit,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             door_closed,
  output logic [BCD_W-1:0] sec_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] mins,
  output logic             mag_on,
  output logic             done,
  output logic [2:0]       state
);

  localparam logic [BCD_W-1:0] LP_MAX_MINS   = BCD_W'(MAX_MINS);
  localparam logic [BCD_W-1:0] LP_QUICK_TENS = BCD_W'(QUICK_SECS_TENS);

  logic [2:0]       r_state;
  logic             r_mag_on;
  logic             r_done;

  logic [2:0]       w_nstate;
  logic             w_done_n;
  logic             w_clr;
  logic             w_load;
  logic             w_shift;
  logic             w_dec;
  logic [BCD_W-1:0] w_ld_mins;
  logic [BCD_W-1:0] w_ld_tens;
  logic [BCD_W-1:0] w_ld_ones;
  logic             w_zero;
  logic             w_one;
  logic             w_key_ok;
  logic             w_start_act;
  logic             w_stop_act;

  bcd_down_counter u_cnt (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_load    (w_load),
    .i_ld_mins (w_ld_mins),
    .i_ld_tens (w_ld_tens),
    .i_ld_ones (w_ld_ones),
    .i_shift   (w_shift),
    .i_digit   (key_digit),
    .i_dec     (w_dec),
    .o_mins    (mins),
    .o_tens    (sec_tens),
    .o_ones    (sec_ones),
    .o_zero    (w_zero)
  );

  assign w_one    = (mins == '0) && (sec_tens == '0) && (sec_ones == 4'd1);
  assign w_key_ok = (key_digit <= SEC_ONES_MAX) && (sec_ones <= SEC_TENS_MAX) &&
                    (sec_tens <= LP_MAX_MINS);
  assign w_stop_act = stop && (r_state != ST_IDLE);

`ifdef MICROWAVE_QUICK_START_EN
  logic [BCD_W-1:0] w_add_mins;
  logic [BCD_W-1:0] w_add_tens;
  logic [BCD_W-1:0] w_add_ones;

  assign w_start_act = start && door_closed && (r_state != ST_COOK);

  // +30 s in BCD: tens gains 3 with a carry into minutes, saturating at MAX_MINS:59.
  always_comb begin
    w_add_ones = sec_ones;
    if (sec_tens >= 4'd3) begin
      w_add_tens = sec_tens - 4'd3;
      w_add_mins = mins + 4'd1;
    end else begin
      w_add_tens = sec_tens + 4'd3;
      w_add_mins = mins;
    end
    if (w_add_mins > LP_MAX_MINS) begin
      w_add_mins = LP_MAX_MINS;
      w_add_tens = SEC_TENS_MAX;
      w_add_ones = SEC_ONES_MAX;
    end
  end
`else
  assign w_start_act = start && door_closed && !w_zero &&
                       ((r_state == ST_SET) || (r_state == ST_PAUSE));
`endif

  always_comb begin
    w_nstate  = r_state;
    w_done_n  = 1'b0;
    w_clr     = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_dec     = 1'b0;
    w_ld_mins = '0;
    w_ld_tens = LP_QUICK_TENS;
    w_ld_ones = '0;
    if (clear) begin
      w_clr    = 1'b1;
      w_nstate = ST_IDLE;
    end else if (w_stop_act) begin
      if (r_state == ST_COOK) begin
        w_nstate = ST_PAUSE;
      end else begin
        w_clr    = 1'b1;
        w_nstate = ST_IDLE;
      end
    end else if ((r_state == ST_COOK) && !door_closed) begin
      w_nstate = ST_PAUSE;
    end else if (w_start_act) begin
      w_nstate = ST_COOK;
`ifdef MICROWAVE_QUICK_START_EN
      w_load = 1'b1;
      if ((r_state == ST_SET) || (r_state == ST_PAUSE)) begin
        w_ld_mins = w_add_mins;
        w_ld_tens = w_add_tens;
        w_ld_ones = w_add_ones;
      end
`endif
    end else if (key_valid && (r_state != ST_COOK)) begin
      // From DONE the display restarts at 0:00, so the shifted result is just 0:0<key>.
      if (r_state == ST_DONE) begin
        if (key_digit <= SEC_ONES_MAX) begin
          w_load    = 1'b1;
          w_ld_tens = '0;
          w_ld_ones = key_digit;
          w_nstate  = ST_SET;
        end else begin
          w_clr    = 1'b1;
          w_nstate = ST_IDLE;
        end
      end else if (w_key_ok) begin
        w_shift  = 1'b1;
        w_nstate = ST_SET;
      end
    end else if (tick_1hz && (r_state == ST_COOK) && !w_zero) begin
      w_dec = 1'b1;
      if (w_one) begin
        w_nstate = ST_DONE;
        w_done_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mag_on <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_mag_on <= (w_nstate == ST_COOK);
      r_done   <= w_done_n;
    end
  end

  assign state  = r_state;
  assign mag_on = r_mag_on;
  assign done   = r_done;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed vector table followed by random stimulus vs a seconds-based model.
module tb_microwave_timer_ctrl;

`ifdef MICROWAVE_QUICK_START_EN
  localparam bit QUICK = 1'b1;
`else
  localparam bit QUICK = 1'b0;
`endif
  localparam int MAXM  = 9;
  localparam int QTENS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       mag_on, done;
  logic [2:0] state;

  microwave_timer_ctrl #(.MAX_MINS(MAXM), .QUICK_SECS_TENS(QTENS)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .mins        (mins),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, clr, stp, sta, kv;
    bit [3:0] kd;
    bit       tk, dr;
    int       es, em, et, eo;
    bit       emag, edone;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  // Model: state number plus the display as a 3-digit decimal value (M*100 + SS).
  int   ms = 0;
  int   mv = 0;
  bit   mdone = 1'b0;

  function automatic int to_secs(int v);
    return (v / 100) * 60 + (v % 100);
  endfunction

  function automatic int to_disp(int s);
    return (s / 60) * 100 + (s % 60);
  endfunction

  task automatic model_step(input bit rst, clr, stp, sta, kv, input bit [3:0] kd,
                            input bit tk, dr);
    int secs;
    int nv;
    mdone = 1'b0;
    secs  = to_secs(mv);
    if (rst || clr) begin
      ms = 0; mv = 0;
    end else if (stp && ms != 0) begin
      if (ms == 2) ms = 3;
      else begin ms = 0; mv = 0; end
    end else if (ms == 2 && !dr) begin
      ms = 3;
    end else if (sta && dr && ((!QUICK && (ms == 1 || ms == 3) && secs != 0) ||
                               (QUICK && ms != 2))) begin
      if (QUICK) begin
        if (ms == 0 || ms == 4) secs = QTENS * 10;
        else secs = (secs + 30 > MAXM * 60 + 59) ? MAXM * 60 + 59 : secs + 30;
        mv = to_disp(secs);
      end
      ms = 2;
    end else if (kv && ms != 2) begin
      if (ms == 4) begin ms = 0; mv = 0; end
      nv = (mv % 100) * 10 + int'(kd);
      if (kd <= 9 && (nv / 10) % 10 <= 5 && nv / 100 <= MAXM) begin
        mv = nv; ms = 1;
      end
    end else if (tk && ms == 2 && secs > 0) begin
      secs = secs - 1;
      mv = to_disp(secs);
      if (secs == 0) begin ms = 4; mdone = 1'b1; end
    end
  endtask

  task automatic add(input bit rst, clr, stp, sta, kv, input bit [3:0] kd, input bit tk, dr,
                     input int es, em, et, eo, input bit emag, edone);
    vec_t v;
    v.rst = rst; v.clr = clr; v.stp = stp; v.sta = sta; v.kv = kv; v.kd = kd;
    v.tk = tk; v.dr = dr; v.es = es; v.em = em; v.et = et; v.eo = eo;
    v.emag = emag; v.edone = edone;
    vq.push_back(v);
  endtask

  task automatic apply(input bit rst, clr, stp, sta, kv, input bit [3:0] kd, input bit tk, dr);
    reset = rst; clear = clr; stop = stp; start = sta; key_valid = kv;
    key_digit = kd; tick_1hz = tk; door_closed = dr;
    @(posedge clk);
    model_step(rst, clr, stp, sta, kv, kd, tk, dr);
    #1;
  endtask

  task automatic check(input string name, input logic [16:0] exp_v);
    logic [16:0] act;
    act = {state, mins, sec_tens, sec_ones, mag_on, done};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got st/m/t/o/mag/done=%h expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [16:0] pack(int s, int m, int t, int o, bit mg, bit dn);
    return {3'(s), 4'(m), 4'(t), 4'(o), mg, dn};
  endfunction

  initial begin
    //  rst clr stp sta kv kd    tk dr   st m t o mag done
    add(1, 0, 0, 0, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd1, 0, 1,  1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 4'd3, 0, 1,  1, 0, 1, 3, 0, 0);
    add(0, 0, 0, 0, 1, 4'd0, 0, 1,  1, 1, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 1, 3, 0, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 1, 1,  2, 1, 2, 9, 1, 0);
    add(0, 0, 1, 0, 0, 4'd0, 0, 1,  3, 1, 2, 9, 0, 0);
    add(0, 0, 1, 0, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd1, 0, 1,  1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 4'd0, 0, 1,  1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd0, 0, 1,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 1, 1,  2, 0, 5, 9, 1, 0);
    add(0, 1, 0, 0, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd1, 0, 1,  1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 1, 1,  4, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 4'd0, 1, 1,  4, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd7, 0, 1,  1, 0, 0, 7, 0, 0);
    add(0, 0, 0, 0, 1, 4'd8, 0, 1,  1, 0, 0, 7, 0, 0);
    add(0, 0, 0, 0, 1, 4'hA, 0, 1,  1, 0, 0, 7, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 1, 1,  2, 0, 0, 7, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 1, 1,  2, 0, 0, 6, 1, 0);
    add(0, 1, 0, 0, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd4, 0, 1,  1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 1, 4'd5, 0, 1,  1, 0, 4, 5, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 0, 4, 5, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 1, 0,  3, 0, 4, 5, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 0,  3, 0, 4, 5, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 0, 4, 5, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 1, 1,  2, 0, 4, 4, 1, 0);
    add(0, 0, 0, 0, 1, 4'd3, 0, 1,  2, 0, 4, 4, 1, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 0, 4, 4, 1, 0);
    add(0, 0, 1, 0, 0, 4'd0, 0, 1,  3, 0, 4, 4, 0, 0);
    add(0, 0, 0, 0, 1, 4'd2, 0, 1,  1, 4, 4, 2, 0, 0);
    add(0, 1, 0, 1, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd0, 0, 1,  1, 0, 0, 0, 0, 0);
    if (QUICK) add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 0, 3, 0, 1, 0);
    else       add(0, 0, 0, 1, 0, 4'd0, 0, 1,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    if (QUICK) add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 0, 3, 0, 1, 0);
    else       add(0, 0, 0, 1, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 4'd0, 0, 1,  0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd2, 0, 1,  1, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 1, 4'd0, 0, 1,  1, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 4'd0, 0, 1,  1, 2, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 4'd0, 0, 1,  2, 2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 1, 1,  2, 1, 5, 9, 1, 0);
    add(1, 0, 0, 0, 0, 4'd0, 1, 1,  0, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].rst, vq[i].clr, vq[i].stp, vq[i].sta, vq[i].kv, vq[i].kd, vq[i].tk, vq[i].dr);
      check($sformatf("vec%0d", i),
            pack(vq[i].es, vq[i].em, vq[i].et, vq[i].eo, vq[i].emag, vq[i].edone));
    end

    for (int n = 0; n < 3000; n++) begin
      bit rst, clr, stp, sta, kv, tk, dr;
      bit [3:0] kd;
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 59) == 0);
      stp = ($urandom_range(0, 29) == 0);
      sta = ($urandom_range(0, 7) == 0);
      kv  = ($urandom_range(0, 3) == 0);
      kd  = 4'($urandom_range(0, 11));
      tk  = ($urandom_range(0, 1) == 0);
      dr  = ($urandom_range(0, 19) != 0);
      apply(rst, clr, stp, sta, kv, kd, tk, dr);
      check($sformatf("rand%0d", n),
            pack(ms, mv / 100, (mv / 10) % 10, mv % 10, ms == 2, mdone));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
- Sequences the microwave cook timer.
- Accepts keypad digits into an M:SS BCD time, counts it down on a 1 Hz tick while cooking, and gates the magnetron.
- Handles start, stop, clear and door interlock.
- Its three BCD digit outputs drive the 7-segment driver directly (mins, sec_tens, sec_ones).

Parameters:
- MAX_MINS, 9, largest legal minutes digit (0..9). Time range is 0:00..MAX_MINS:59.
- QUICK_SECS_TENS, 3, tens-of-seconds loaded by quick start (Optional Feature only).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tick_1hz  input  1  one-clk-wide pulse, once per second
- key_valid  input  1  one-clk strobe; key_digit is valid
- key_digit  input  4  BCD digit from keypad
- start  input  1  one-clk start/resume strobe
- stop  input  1  one-clk stop/pause strobe
- clear  input  1  one-clk clear strobe
- door_closed  input  1  level; 1 = door latched
- sec_ones  output  4  BCD seconds units
- sec_tens  output  4  BCD seconds tens
- mins  output  4  BCD minutes
- mag_on  output  1  magnetron enable
- done  output  1  one-clk pulse when countdown reaches 0:00
- state  output  3  current FSM state, for debug and display logic

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, digits=0:00, mag_on=0, done=0. Reset mid-cook drops mag_on on the next edge.
- States: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.
- Command priority within one cycle: clear > stop > door-open > start > key_valid > tick_1hz. Only the highest-priority applicable event acts.
- clear, from any state: digits=0:00, mag_on=0, state=IDLE.
- Key entry (IDLE, SET, PAUSE):
  - Shift left: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit.
  - Reject the key (no change) if key_digit>9, if new sec_tens>5, or if new mins>MAX_MINS.
  - An accepted key moves IDLE→SET and PAUSE→SET.
  - Keys are ignored in COOK.
  - In DONE, a key first returns to IDLE with 0:00 and then applies the shift in the same cycle.
- start (SET or PAUSE): if door_closed=1 and time≠0:00, go to COOK with mag_on=1 on the next edge. Otherwise ignore.
- start in COOK, IDLE or DONE is ignored.
- stop: COOK→PAUSE with mag_on=0 and digits held. PAUSE→IDLE with digits=0:00. SET→IDLE with 0:00. DONE→IDLE.
- Door opens (door_closed=0) in COOK: go to PAUSE, mag_on=0. No decrement that cycle, even if tick_1hz=1.
- tick_1hz in COOK decrements the time by 1 s, with the update visible the next cycle:
  - sec_ones 0→9 with borrow.
  - sec_tens 0→5 with borrow.
  - mins decrements.
- Tick at 0:01 in COOK: next cycle digits=0:00, state=DONE, mag_on=0, done=1 for exactly one cycle.
- Ticks outside COOK are ignored. A tick in the same cycle as an accepted start is ignored; the first decrement happens on the following tick.
- Digits never leave legal BCD ranges. Countdown never wraps below 0:00.

Optional Feature:
- Macro: MICROWAVE_QUICK_START_EN.
- Defined: start in IDLE, or in DONE, with door_closed=1 loads 0:QUICK_SECS_TENS0 (default 0:30) and enters COOK with mag_on=1 next cycle. In SET/PAUSE, start additionally adds 30 s, saturating at MAX_MINS:59, and continues cooking.
- Not defined: start in IDLE/DONE is ignored, exactly as in Behaviour.

Decomposition:
- Package microwave_pkg holds:
  - state encoding constants (ST_IDLE..ST_DONE, 3 bits)
  - BCD limit constants (SEC_ONES_MAX=9, SEC_TENS_MAX=5)
  - the 4-bit BCD digit width
- Sub-module bcd_down_counter holds the 3-digit M:SS register with load/shift/decrement/clear controls and a zero flag.
- The top level holds the FSM and command priority only.

Test Plan:
- Reset, then key 1,3,0 → 1:30, state=SET. Start with door_closed=1 → mag_on=1 next cycle, state=COOK.
- Time 1:00 in COOK, one tick → 0:59. Time 0:01, one tick → 0:00, done pulses for 1 cycle, mag_on=0, state=DONE.
- Key 7 then 8 (sec_tens would become 7) → second key rejected, display 0:07. Key 0xA → rejected.
- In COOK at 0:45, drop door_closed in the same cycle as tick_1hz → PAUSE, time stays 0:45, mag_on=0. Close the door and start → COOK resumes from 0:45.
- Assert clear and start together in SET → IDLE, 0:00, mag_on stays 0. Assert reset mid-COOK → all outputs at reset values next edge.
- With MICROWAVE_QUICK_START_EN: start in IDLE → 0:30, COOK. Start again at 9:45 in PAUSE → 9:59 saturated, COOK. Without the macro: start in IDLE → no change.
